// File: rtl/debug_mem_sequencer.sv
// debug_mem_sequencer
// Loads DataRAM and InstRAM through their debug ports from an input stream.
// It then holds RV32Core in reset for a few cycles and lets it run for a fixed
// number of cycles. Finally it dumps both RAMs, word by word, onto an output stream.
module debug_mem_sequencer #(
  parameter int BRAMWORDS  = 4096,
  parameter int RST_CYCLES = 5,
  parameter int RUN_CYCLES = 200000,
  parameter int RD_LAT     = 2
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic        start,

  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  input  logic [31:0] s_data,

  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [31:0] m_data,

  output logic [31:0] CPU_Debug_DataRAM_A2,
  output logic [31:0] CPU_Debug_DataRAM_WD2,
  output logic [3:0]  CPU_Debug_DataRAM_WE2,
  input  logic [31:0] CPU_Debug_DataRAM_RD2,

  output logic [31:0] CPU_Debug_InstRAM_A2,
  output logic [31:0] CPU_Debug_InstRAM_WD2,
  output logic [3:0]  CPU_Debug_InstRAM_WE2,
  input  logic [31:0] CPU_Debug_InstRAM_RD2,

  output logic        CORE_RST,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state
);

  // Word index needs one spare bit so BRAMWORDS itself is representable.
  localparam int KW = $clog2(BRAMWORDS) + 1;
  localparam int LW = $clog2(RD_LAT + 1) + 1;

  localparam logic [KW-1:0] K_LAST   = KW'(BRAMWORDS - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT);
  localparam logic [31:0]   RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0]   RUN_LAST = 32'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_D = 3'd1,
    LOAD_I = 3'd2,
    CRST   = 3'd3,
    RUN    = 3'd4,
    DUMP_D = 3'd5,
    DUMP_I = 3'd6,
    DONE   = 3'd7
  } stateT;

  stateT         curState;
  stateT         nextState;

  logic [KW-1:0] wordIdx;
  logic [31:0]   cycleCnt;
  logic [LW-1:0] latCnt;
  logic          dumpValid;
  logic [31:0]   dumpData;

  logic          isLoad;
  logic          loadXfer;
  logic          loadEnd;
  logic          wordLast;
  logic          dumpXfer;
  logic [31:0]   wordAddr;
  logic [31:0]   readData;

  assign isLoad   = (curState == LOAD_D) || (curState == LOAD_I);
  assign loadXfer = isLoad && s_valid;
  assign wordLast = (wordIdx == K_LAST);
  assign loadEnd  = loadXfer && (s_last || wordLast);
  assign dumpXfer = dumpValid && m_ready;
  assign wordAddr = {{(30-KW){1'b0}}, wordIdx, 2'b00};
  assign readData = (curState == DUMP_I) ? CPU_Debug_InstRAM_RD2 : CPU_Debug_DataRAM_RD2;
  assign state    = curState;

  // State register; reset drops straight back to IDLE and abandons any sequence.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      curState <= IDLE;
    end else begin
      curState <= nextState;
    end
  end

  // Next-state decision from the current phase and its completion condition.
  always_comb begin
    nextState = curState;
    case (curState)
      IDLE:    if (start) nextState = LOAD_D;
      LOAD_D:  if (loadEnd) nextState = LOAD_I;
      LOAD_I:  if (loadEnd) nextState = CRST;
      CRST:    if (cycleCnt == RST_LAST) nextState = RUN;
      RUN:     if (cycleCnt == RUN_LAST) nextState = DUMP_D;
      DUMP_D:  if (dumpXfer && wordLast) nextState = DUMP_I;
      DUMP_I:  if (dumpXfer && wordLast) nextState = DONE;
      DONE:    if (start) nextState = LOAD_D;
      default: nextState = IDLE;
    endcase
  end

  // Word index, cycle counters and the dump holding register.
  // The index returns to 0 at the end of each phase, so every phase starts at word 0.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      wordIdx   <= '0;
      cycleCnt  <= '0;
      latCnt    <= '0;
      dumpValid <= 1'b0;
      dumpData  <= '0;
    end else begin
      case (curState)
        LOAD_D, LOAD_I: begin
          if (loadXfer) begin
            wordIdx <= loadEnd ? '0 : wordIdx + KW'(1);
          end
        end
        CRST: begin
          cycleCnt <= (cycleCnt == RST_LAST) ? '0 : cycleCnt + 32'd1;
        end
        RUN: begin
          cycleCnt <= (cycleCnt == RUN_LAST) ? '0 : cycleCnt + 32'd1;
        end
        DUMP_D, DUMP_I: begin
          if (!dumpValid) begin
            // The address has been stable for RD_LAT cycles once latCnt reaches RD_LAT.
            if (latCnt == LAT_LAST) begin
              dumpData  <= readData;
              dumpValid <= 1'b1;
              latCnt    <= '0;
            end else begin
              latCnt <= latCnt + LW'(1);
            end
          end else if (m_ready) begin
            dumpValid <= 1'b0;
            wordIdx   <= wordLast ? '0 : wordIdx + KW'(1);
          end
        end
        default: begin
          wordIdx   <= '0;
          cycleCnt  <= '0;
          latCnt    <= '0;
          dumpValid <= 1'b0;
        end
      endcase
    end
  end

  // Per-state outputs. A write strobe is raised only on an accepted load beat, and WD2 stays 0 otherwise.
  always_comb begin
    s_ready               = 1'b0;
    CORE_RST              = 1'b0;
    busy                  = 1'b1;
    done                  = 1'b0;
    m_valid               = dumpValid;
    m_data                = dumpData;
    m_last                = 1'b0;
    CPU_Debug_DataRAM_A2  = '0;
    CPU_Debug_DataRAM_WD2 = '0;
    CPU_Debug_DataRAM_WE2 = '0;
    CPU_Debug_InstRAM_A2  = '0;
    CPU_Debug_InstRAM_WD2 = '0;
    CPU_Debug_InstRAM_WE2 = '0;
    case (curState)
      IDLE: begin
        CORE_RST = 1'b1;
        busy     = 1'b0;
      end
      LOAD_D: begin
        s_ready              = 1'b1;
        CPU_Debug_DataRAM_A2 = wordAddr;
        if (s_valid) begin
          CPU_Debug_DataRAM_WE2 = 4'b1111;
          CPU_Debug_DataRAM_WD2 = s_data;
        end
      end
      LOAD_I: begin
        s_ready              = 1'b1;
        CPU_Debug_InstRAM_A2 = wordAddr;
        if (s_valid) begin
          CPU_Debug_InstRAM_WE2 = 4'b1111;
          CPU_Debug_InstRAM_WD2 = s_data;
        end
      end
      CRST: begin
        CORE_RST = 1'b1;
      end
      DUMP_D: begin
        CPU_Debug_DataRAM_A2 = wordAddr;
      end
      DUMP_I: begin
        CPU_Debug_InstRAM_A2 = wordAddr;
        m_last               = dumpValid && wordLast;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_debug_mem_sequencer.sv
// tb_debug_mem_sequencer
// Directed and randomized bench for debug_mem_sequencer.
// The bench models both RAMs, including a read pipeline that is RD_LAT cycles deep.
// It also keeps a reference copy of what each RAM should hold, built from the words sent on the load stream.
module tb_debug_mem_sequencer;

  localparam int BRAMWORDS  = 8;
  localparam int RST_CYCLES = 5;
  localparam int RUN_CYCLES = 20;
  localparam int RD_LAT     = 2;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST_N;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [31:0] m_data;
  logic [31:0] dA2, dWd2, dRd2;
  logic [3:0]  dWe2;
  logic [31:0] iA2, iWd2, iRd2;
  logic [3:0]  iWe2;
  logic        CORE_RST;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  int testsRun  = 0;
  int failCount = 0;

  logic [31:0] tbData  [BRAMWORDS];
  logic [31:0] tbInst  [BRAMWORDS];
  logic [31:0] refData [BRAMWORDS];
  logic [31:0] refInst [BRAMWORDS];
  logic [31:0] dPipe   [RD_LAT];
  logic [31:0] iPipe   [RD_LAT];

  assign dRd2 = tbData[dPipe[RD_LAT-1][4:2]];
  assign iRd2 = tbInst[iPipe[RD_LAT-1][4:2]];

  debug_mem_sequencer #(
    .BRAMWORDS (BRAMWORDS),
    .RST_CYCLES(RST_CYCLES),
    .RUN_CYCLES(RUN_CYCLES),
    .RD_LAT    (RD_LAT)
  ) dut (
    .CPU_CLK              (CPU_CLK),
    .CPU_RST_N            (CPU_RST_N),
    .start                (start),
    .s_valid              (s_valid),
    .s_ready              (s_ready),
    .s_last               (s_last),
    .s_data               (s_data),
    .m_valid              (m_valid),
    .m_ready              (m_ready),
    .m_last               (m_last),
    .m_data               (m_data),
    .CPU_Debug_DataRAM_A2 (dA2),
    .CPU_Debug_DataRAM_WD2(dWd2),
    .CPU_Debug_DataRAM_WE2(dWe2),
    .CPU_Debug_DataRAM_RD2(dRd2),
    .CPU_Debug_InstRAM_A2 (iA2),
    .CPU_Debug_InstRAM_WD2(iWd2),
    .CPU_Debug_InstRAM_WE2(iWe2),
    .CPU_Debug_InstRAM_RD2(iRd2),
    .CORE_RST             (CORE_RST),
    .busy                 (busy),
    .done                 (done),
    .state                (state)
  );

  // Free-running clock.
  always #5 CPU_CLK = ~CPU_CLK;

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after the falling edge, then settle before sampling.
  task automatic applyStimulus(input logic st, input logic sv, input logic sl,
                               input logic [31:0] sd, input logic mr);
    @(negedge CPU_CLK);
    start   = st;
    s_valid = sv;
    s_last  = sl;
    s_data  = sd;
    m_ready = mr;
    #1;
  endtask

  // Commit this cycle's RAM writes and advance the read pipelines, one step after the rising edge.
  task automatic finishCycle();
    logic [31:0] da, dw, ia, iw;
    logic [3:0]  de, ie;
    da = dA2; dw = dWd2; de = dWe2;
    ia = iA2; iw = iWd2; ie = iWe2;
    @(posedge CPU_CLK);
    #1;
    if (de != 4'b0000) tbData[da[4:2]] = dw;
    if (ie != 4'b0000) tbInst[ia[4:2]] = iw;
    for (int i = RD_LAT - 1; i > 0; i--) begin
      dPipe[i] = dPipe[i-1];
      iPipe[i] = iPipe[i-1];
    end
    dPipe[0] = da;
    iPipe[0] = ia;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_state"},   {29'b0, state}, 32'd0);
    checkOutput({tag, "_corerst"}, {31'b0, CORE_RST}, 32'd1);
    checkOutput({tag, "_sready"},  {31'b0, s_ready}, 32'd0);
    checkOutput({tag, "_mvalid"},  {31'b0, m_valid}, 32'd0);
    checkOutput({tag, "_mlast"},   {31'b0, m_last}, 32'd0);
    checkOutput({tag, "_mdata"},   m_data, 32'd0);
    checkOutput({tag, "_dport"},   dA2 | dWd2 | {28'b0, dWe2}, 32'd0);
    checkOutput({tag, "_iport"},   iA2 | iWd2 | {28'b0, iWe2}, 32'd0);
    checkOutput({tag, "_busy"},    {31'b0, busy}, 32'd0);
    checkOutput({tag, "_done"},    {31'b0, done}, 32'd0);
  endtask

  task automatic pulseStart(input int expState);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("start_state", {29'b0, state}, 32'(expState));
    checkOutput("start_corerst", {31'b0, CORE_RST}, (expState == 0) ? 32'd1 : 32'd0);
    checkOutput("start_busy", {31'b0, busy}, 32'd0);
    checkOutput("start_done", {31'b0, done}, (expState == 7) ? 32'd1 : 32'd0);
    finishCycle();
  endtask

  // Send nBeats words into one RAM. The stream can pause for stallLen cycles before beat stallAt, and can also pause at random.
  task automatic loadPhase(input bit isInst, input int nBeats, input bit useLast,
                           input bit fixed, input logic [31:0] base,
                           input int stallAt, input int stallLen, input bit randStall);
    int beat, cyc, gapLeft;
    bit gap, lst;
    logic [31:0] w;
    logic [31:0] oA, oW, xW;
    logic [3:0]  oE, xE;
    beat = 0; cyc = 0; gapLeft = stallLen;
    while (beat < nBeats && cyc < 200) begin
      gap = 1'b0;
      if (beat == stallAt && gapLeft > 0) begin
        gap = 1'b1;
        gapLeft--;
      end else if (randStall && $urandom_range(0, 3) == 0) begin
        gap = 1'b1;
      end
      w   = fixed ? base + 32'(beat) : $urandom;
      lst = useLast && (beat == nBeats - 1);
      if (gap) applyStimulus(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
      else     applyStimulus(1'b0, 1'b1, lst, w, 1'b0);
      oA = isInst ? iA2 : dA2;   oW = isInst ? iWd2 : dWd2;  oE = isInst ? iWe2 : dWe2;
      xW = isInst ? dWd2 : iWd2; xE = isInst ? dWe2 : iWe2;
      checkOutput("load_state", {29'b0, state}, isInst ? 32'd2 : 32'd1);
      checkOutput("load_sready", {31'b0, s_ready}, 32'd1);
      checkOutput("load_busy", {31'b0, busy}, 32'd1);
      checkOutput("load_corerst", {31'b0, CORE_RST}, 32'd0);
      checkOutput("load_other_we", {28'b0, xE}, 32'd0);
      checkOutput("load_other_wd", xW, 32'd0);
      if (gap) begin
        checkOutput("stall_we", {28'b0, oE}, 32'd0);
        checkOutput("stall_wd", oW, 32'd0);
      end else begin
        checkOutput("load_we", {28'b0, oE}, 32'hF);
        checkOutput("load_addr", oA, 32'(beat * 4));
        checkOutput("load_wd", oW, w);
        if (isInst) refInst[beat] = w;
        else        refData[beat] = w;
        beat++;
      end
      finishCycle();
      cyc++;
    end
    if (cyc >= 200) checkOutput("load_timeout", 32'(beat), 32'(nBeats));
  endtask

  // Core-reset and run window. If abortAt is in range, reset is pulsed during that run cycle.
  task automatic runPhase(input int abortAt);
    for (int i = 0; i < RST_CYCLES; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("crst_state", {29'b0, state}, 32'd3);
      checkOutput("crst_corerst", {31'b0, CORE_RST}, 32'd1);
      finishCycle();
    end
    for (int i = 0; i < RUN_CYCLES; i++) begin
      if (i == abortAt) begin
        @(negedge CPU_CLK);
        CPU_RST_N = 1'b0;
        #1;
        checkResetValues("midrun_rst");
        finishCycle();
        @(negedge CPU_CLK);
        CPU_RST_N = 1'b1;
        #1;
        checkOutput("postrst_state", {29'b0, state}, 32'd0);
        finishCycle();
        for (int j = 0; j < 3; j++) begin
          applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
          checkOutput("postrst_idle", {29'b0, state}, 32'd0);
          checkOutput("postrst_corerst", {31'b0, CORE_RST}, 32'd1);
          finishCycle();
        end
        return;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("run_state", {29'b0, state}, 32'd4);
      checkOutput("run_corerst", {31'b0, CORE_RST}, 32'd0);
      checkOutput("run_we", {28'b0, dWe2 | iWe2}, 32'd0);
      finishCycle();
    end
  endtask

  // Drain all 2*BRAMWORDS words. mode 0 keeps m_ready high, mode 1 repeats 1,0,0,1, mode 2 is random.
  // start is pulsed at dump cycle startAt.
  task automatic dumpPhase(input int mode, input int startAt);
    logic [31:0] expQ[$];
    int got, cyc;
    bit pend;
    logic r;
    logic [31:0] aA;
    expQ = {};
    for (int i = 0; i < BRAMWORDS; i++) expQ.push_back(refData[i]);
    for (int i = 0; i < BRAMWORDS; i++) expQ.push_back(refInst[i]);
    got = 0; cyc = 0; pend = 1'b0;
    while (got < 2 * BRAMWORDS && cyc < 1000) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      applyStimulus((cyc == startAt) ? 1'b1 : 1'b0, 1'b0, 1'b0, 32'd0, r);
      checkOutput("dump_state", {29'b0, state}, (got < BRAMWORDS) ? 32'd5 : 32'd6);
      checkOutput("dump_we", {28'b0, dWe2 | iWe2}, 32'd0);
      checkOutput("dump_wd", dWd2 | iWd2, 32'd0);
      checkOutput("dump_corerst", {31'b0, CORE_RST}, 32'd0);
      aA = (got < BRAMWORDS) ? dA2 : iA2;
      checkOutput("dump_addr", aA, 32'((got % BRAMWORDS) * 4));
      if (pend) checkOutput("dump_hold_valid", {31'b0, m_valid}, 32'd1);
      if (m_valid) begin
        checkOutput("dump_data", m_data, expQ[got]);
        checkOutput("dump_last", {31'b0, m_last}, (got == 2 * BRAMWORDS - 1) ? 32'd1 : 32'd0);
        if (r) begin
          got++;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
        end
      end else begin
        checkOutput("dump_last_idle", {31'b0, m_last}, 32'd0);
      end
      finishCycle();
      cyc++;
    end
    if (cyc >= 1000) checkOutput("dump_timeout", 32'(got), 32'(2 * BRAMWORDS));
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("done_state", {29'b0, state}, 32'd7);
    checkOutput("done_flag", {31'b0, done}, 32'd1);
    checkOutput("done_busy", {31'b0, busy}, 32'd0);
    checkOutput("done_mvalid", {31'b0, m_valid}, 32'd0);
    checkOutput("done_corerst", {31'b0, CORE_RST}, 32'd0);
    finishCycle();
  endtask

  // Directed sequence: full load, early s_last with stalls and backpressure, mid-run reset, then random reruns.
  initial begin
    int nd, ni;
    CPU_RST_N = 1'b0;
    start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    for (int i = 0; i < BRAMWORDS; i++) begin
      tbData[i]  = $urandom;
      tbInst[i]  = $urandom;
      refData[i] = tbData[i];
      refInst[i] = tbInst[i];
    end
    for (int i = 0; i < RD_LAT; i++) begin
      dPipe[i] = '0;
      iPipe[i] = '0;
    end
    #2;
    checkResetValues("rst_init");
    @(negedge CPU_CLK);
    CPU_RST_N = 1'b1;
    #1;
    checkOutput("release_state", {29'b0, state}, 32'd0);
    finishCycle();

    $display("[TB] full load and dump");
    pulseStart(0);
    loadPhase(1'b0, 8, 1'b0, 1'b1, 32'h10, -1, 0, 1'b0);
    loadPhase(1'b1, 8, 1'b0, 1'b1, 32'hA0, -1, 0, 1'b0);
    runPhase(-1);
    dumpPhase(0, -1);

    $display("[TB] early s_last, load stall, backpressure, start during dump");
    pulseStart(7);
    loadPhase(1'b0, 3, 1'b1, 1'b0, 32'd0, -1, 0, 1'b0);
    loadPhase(1'b1, 8, 1'b1, 1'b0, 32'd0, 3, 4, 1'b0);
    runPhase(-1);
    dumpPhase(1, 3);

    $display("[TB] reset during run then replay");
    pulseStart(7);
    loadPhase(1'b0, 8, 1'b0, 1'b0, 32'd0, -1, 0, 1'b1);
    loadPhase(1'b1, 5, 1'b1, 1'b0, 32'd0, -1, 0, 1'b1);
    runPhase(10);
    pulseStart(0);
    loadPhase(1'b0, 4, 1'b1, 1'b0, 32'd0, -1, 0, 1'b1);
    loadPhase(1'b1, 8, 1'b1, 1'b0, 32'd0, -1, 0, 1'b1);
    runPhase(-1);
    dumpPhase(2, -1);

    $display("[TB] random reruns");
    for (int n = 0; n < 3; n++) begin
      nd = $urandom_range(1, BRAMWORDS);
      ni = $urandom_range(1, BRAMWORDS);
      pulseStart(7);
      loadPhase(1'b0, nd, (nd < BRAMWORDS) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, 32'd0, -1, 0, 1'b1);
      loadPhase(1'b1, ni, (ni < BRAMWORDS) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, 32'd0, -1, 0, 1'b1);
      runPhase(-1);
      dumpPhase(2, -1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
